// File: rtl/wb_sram_responder.sv
// ============================================================================
// Module   : wb_sram_responder
// Purpose  : Wishbone classic (B4) responder backed by a word-addressed RAM,
//            with byte-select writes, fixed wait states and out-of-window
//            error termination.
// Options  : define WB_SRAM_RANDOM_STALL_EN to add 0..3 LFSR-driven stall
//            cycles per transfer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_sram_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  output logic [31:0] wb_dat_r,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  output logic        wb_ack,
  output logic        wb_err
);

  localparam int          c_depth     = 1 << ADDR_WIDTH;
  localparam logic [29:0] c_base_word = BASE_ADDR[31:2];
  localparam logic [4:0]  c_wait      = 5'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [4:0]              r_cnt;
  logic                    r_ack;
  logic                    r_err;
  logic [31:0]             r_dat_r;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic                    r_we;
  logic [3:0]              r_sel;
  logic [31:0]             r_dat_w;
  logic                    r_in_range;
  logic [31:0]             r_mem [c_depth];

  logic                    w_req;
  logic [29:0]             w_diff;
  logic                    w_in_range;
  logic [4:0]              w_extra;
  logic [4:0]              w_total;
  logic                    w_fire;
  logic [ADDR_WIDTH-1:0]   w_op_idx;
  logic                    w_op_we;
  logic [3:0]              w_op_sel;
  logic [31:0]             w_op_dat;
  logic                    w_op_in_range;

  assign w_req  = wb_cyc & wb_stb;
  assign w_diff = wb_adr - c_base_word;

  // Wrap-around subtraction makes addresses below the base land far out of range.
  generate
    if (ADDR_WIDTH >= 30) begin : g_range_full
      assign w_in_range = 1'b1;
    end else begin : g_range_part
      assign w_in_range = (w_diff[29:ADDR_WIDTH] == '0);
    end
  endgenerate

`ifdef WB_SRAM_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_extra = {3'b000, r_lfsr[1:0]};
`else
  assign w_extra = 5'd0;
`endif

  assign w_total = c_wait + w_extra;

  // A zero-wait transfer commits on its capture edge, so operands come straight
  // from the bus in IDLE and from the capture registers in WAIT.
  assign w_fire = ((r_state == S_IDLE) && w_req && (w_total == 5'd0)) ||
                  ((r_state == S_WAIT) && w_req && (r_cnt == 5'd0));

  assign w_op_idx      = (r_state == S_IDLE) ? w_diff[ADDR_WIDTH-1:0] : r_idx;
  assign w_op_we       = (r_state == S_IDLE) ? wb_we                  : r_we;
  assign w_op_sel      = (r_state == S_IDLE) ? wb_sel                 : r_sel;
  assign w_op_dat      = (r_state == S_IDLE) ? wb_dat_w               : r_dat_w;
  assign w_op_in_range = (r_state == S_IDLE) ? w_in_range             : r_in_range;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_r <= 32'd0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_r <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_total == 5'd0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= w_total - 5'd1;
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 5'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_fire) begin
        r_ack <= w_op_in_range;
        r_err <= !w_op_in_range;
        if (w_op_in_range && !w_op_we) begin
          r_dat_r <= r_mem[w_op_idx];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if ((r_state == S_IDLE) && w_req) begin
      r_idx      <= w_diff[ADDR_WIDTH-1:0];
      r_we       <= wb_we;
      r_sel      <= wb_sel;
      r_dat_w    <= wb_dat_w;
      r_in_range <= w_in_range;
    end
  end

  // RAM contents are deliberately left out of reset; a reset edge only blocks the write.
  always_ff @(posedge clock) begin
    if (!reset && w_fire && w_op_in_range && w_op_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_op_sel[i]) begin
          r_mem[w_op_idx][8*i +: 8] <= w_op_dat[8*i +: 8];
        end
      end
    end
  end

  assign wb_ack   = r_ack;
  assign wb_err   = r_err;
  assign wb_dat_r = r_dat_r;

endmodule

`default_nettype wire
